seq_magnitude_compare: RTL and testbench

//   Parametrised multi-cycle magnitude comparator, successor to the 4/8-bit cascade comparators.

---
 rtl/seq_magnitude_compare.sv | 114 +++++++++++
 tb/tb_seq_magnitude_compare.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator: DIGIT bits per clock, MSB digit first.
// Ports: iClk/iRst, iStart/iSigned/iData_a/iData_b in; oBusy/oDone/oResult/oDigits out.
module seq_magnitude_compare #(
    parameter  int WIDTH = 32,
    parameter  int DIGIT = 4,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oResult,
    output logic [CW-1:0]    oDigits
);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    dig_q, dig_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;

    logic [CW-1:0]    cnt_inc;
    logic [DIGIT-1:0] top_a;
    logic [DIGIT-1:0] top_b;
    logic [WIDTH-1:0] msb_mask;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign msb_mask = {iSigned, {(WIDTH-1){1'b0}}};
    assign top_a    = a_q[WIDTH-1 -: DIGIT];
    assign top_b    = b_q[WIDTH-1 -: DIGIT];
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d     = iData_a ^ msb_mask;
                    b_d     = iData_b ^ msb_mask;
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_inc;
                if (top_a != top_b) begin
                    res_d   = (top_a > top_b) ? 3'b100 : 3'b001;
                    dig_d   = cnt_inc;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_inc == CW'(NDIG)) begin
                    res_d   = 3'b010;
                    dig_d   = cnt_inc;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    a_d = a_q << DIGIT;
                    b_d = b_q << DIGIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            res_q   <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign oBusy   = (state_q == CMP);
    assign oDone   = done_q;
    assign oResult = res_q;
    assign oDigits = dig_q;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Scoreboard bench for seq_magnitude_compare at DIGIT = 4, 1 and 32.
// Directed vectors; a negedge monitor checks every oDone against the queue.
module tb_seq_magnitude_compare;

    logic        clk;
    logic        rst;
    logic        sgn;
    logic [31:0] da;
    logic [31:0] db;
    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  res_v [3];
    logic [5:0]  dig_v [3];
    logic [3:0]  dig0;
    logic [5:0]  dig1;
    logic [0:0]  dig2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int busy_tot [3];

    typedef struct {
        int         idx;
        logic [2:0] res;
        int         k;
        int         cyc;
        int         bz;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [2:0]  res;
        int          k0;
        int          k1;
        int          k2;
    } vec_t;

    vec_t vecs[6];

    seq_magnitude_compare #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .iClk(clk), .iRst(rst), .iStart(start_v[0]), .iSigned(sgn),
        .iData_a(da), .iData_b(db), .oBusy(busy_v[0]), .oDone(done_v[0]),
        .oResult(res_v[0]), .oDigits(dig0)
    );

    seq_magnitude_compare #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .iClk(clk), .iRst(rst), .iStart(start_v[1]), .iSigned(sgn),
        .iData_a(da), .iData_b(db), .oBusy(busy_v[1]), .oDone(done_v[1]),
        .oResult(res_v[1]), .oDigits(dig1)
    );

    seq_magnitude_compare #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .iClk(clk), .iRst(rst), .iStart(start_v[2]), .iSigned(sgn),
        .iData_a(da), .iData_b(db), .oBusy(busy_v[2]), .oDone(done_v[2]),
        .oResult(res_v[2]), .oDigits(dig2)
    );

    assign dig_v[0] = {2'b00, dig0};
    assign dig_v[1] = dig1;
    assign dig_v[2] = {5'b00000, dig2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever any instance raises oDone.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_v[i]) busy_tot[i]++;
            if (done_v[i]) begin
                if (sb.size() == 0 || sb[0].idx != i) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done inst%0d: got done=1 expected none", i);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("result inst%0d", i), int'(res_v[i]), int'(e.res));
                    check($sformatf("digits inst%0d", i), int'(dig_v[i]), e.k);
                    check($sformatf("latency inst%0d", i), cyc, e.cyc);
                    check($sformatf("busy_cycles inst%0d", i), busy_tot[i] - e.bz, e.k);
                end
            end
        end
    end

    // Called right after a negedge: drive a request and record its expectation.
    task automatic issue(int idx, logic s, logic [31:0] a, logic [31:0] b,
                         logic [2:0] er, int ek);
        exp_t e;
        sgn          = s;
        da           = a;
        db           = b;
        start_v[idx] = 1'b1;
        e.idx = idx;
        e.res = er;
        e.k   = ek;
        e.cyc = cyc + 1 + ek;
        e.bz  = busy_tot[idx];
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(int idx, logic s, logic [31:0] a, logic [31:0] b,
                       logic [2:0] er, int ek);
        @(negedge clk);
        issue(idx, s, a, b, er, ek);
        @(negedge clk);
        start_v[idx] = 1'b0;
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 1, 1, 1};
        vecs[1] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010, 8, 32, 1};
        vecs[2] = '{32'h1234_5670, 32'h1234_5678, 1'b0, 3'b001, 8, 29, 1};
        vecs[3] = '{32'h1234_5678, 32'h1234_5670, 1'b0, 3'b100, 8, 29, 1};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 1, 1, 1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1, 1, 1};
        for (int i = 0; i < 3; i++) busy_tot[i] = 0;

        rst     = 1'b1;
        sgn     = 1'b0;
        da      = '0;
        db      = '0;
        start_v = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy inst%0d", i), int'(busy_v[i]), 0);
            check($sformatf("rst_done inst%0d", i), int'(done_v[i]), 0);
            check($sformatf("rst_result inst%0d", i), int'(res_v[i]), 0);
            check($sformatf("rst_digits inst%0d", i), int'(dig_v[i]), 0);
        end

        for (int v = 0; v < 6; v++) begin
            run(0, vecs[v].sg, vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].k0);
            run(1, vecs[v].sg, vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].k1);
            run(2, vecs[v].sg, vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].k2);
        end

        // Start while busy must be ignored.
        @(negedge clk);
        issue(0, 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010, 8);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        da         = 32'h0000_0000;
        db         = 32'h0000_0001;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle();

        // Start in the oDone cycle is accepted.
        @(negedge clk);
        issue(0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1);
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_v[0]) break;
            @(negedge clk);
        end
        issue(0, 1'b0, 32'h1234_5670, 32'h1234_5678, 3'b001, 8);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle();

        // Reset three cycles into an 8-digit compare aborts it.
        @(negedge clk);
        issue(0, 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010, 8);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_done", int'(done_v[0]), 0);
        check("abort_result", int'(res_v[0]), 0);
        check("abort_digits", int'(dig_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_busy_after", int'(busy_v[0]), 0);

        // Post-reset compare still works.
        run(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
